// File: rtl/prog_loader_pkg.sv
// Shared constants and state type for the program-memory loader.
package prog_loader_pkg;

    localparam int         PC_WIDTH          = 8;
    localparam int         INSTRUCTION_WIDTH = 16;
    localparam logic [7:0] SYNC_BYTE         = 8'hA5;
    localparam int         BPW               = INSTRUCTION_WIDTH / 8;
    // One extra bit so a full-depth frame (N == 2**PC_WIDTH) can be counted.
    localparam int         IDX_WIDTH         = PC_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Packs a byte stream MSB-first into BPW-byte words; word_done marks the byte
// that completes a word, with word_out already holding the finished word.
module word_packer #(
    parameter int BPW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    output logic [BPW*8-1:0] word_out,
    output logic             word_done
);

    localparam int W  = BPW * 8;
    localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPW - 1);

    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign word_out  = (shift_q << 8) | W'(byte_in);
    assign word_done = byte_valid && (cnt_q == LAST);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = word_out;
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader into instruction memory; holds the core in reset
// until a frame arrives with a matching XOR checksum.
//   state     | meaning
//   ST_IDLE   | hunting for SYNC_BYTE, other bytes dropped
//   ST_LEN_HI | expecting word-count high byte
//   ST_LEN_LO | expecting word-count low byte, range check
//   ST_DATA   | packing payload bytes, one write per word
//   ST_CHECK  | expecting checksum byte
//   ST_DONE   | load good, core released, waits for load_req
//   ST_ERROR  | load rejected, core held, waits for load_req
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         load_req,
    output logic                         mem_we,
    output logic [PC_WIDTH-1:0]          mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    output logic                         core_rst,
    output logic                         done,
    output logic                         error
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** PC_WIDTH);

    loader_state_t                  state_q, state_d;
    logic [15:0]                    len_q, len_d;
    logic [7:0]                     chk_q, chk_d;
    logic [IDX_WIDTH-1:0]           widx_q, widx_d;
    logic                           mem_we_q, mem_we_d;
    logic [PC_WIDTH-1:0]            mem_addr_q, mem_addr_d;
    logic [INSTRUCTION_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                           core_rst_q, core_rst_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;

    logic                           accept;
    logic                           pk_clr, pk_valid, pk_done;
    logic [INSTRUCTION_WIDTH-1:0]   pk_word;
    logic [15:0]                    len_in;

    assign in_ready = !rst && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign accept   = in_valid && in_ready;
    assign pk_clr   = accept && (state_q == ST_IDLE) && (in_data == SYNC_BYTE);
    assign pk_valid = accept && (state_q == ST_DATA);
    assign len_in   = {len_q[15:8], in_data};

    word_packer #(.BPW(BPW)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .byte_valid(pk_valid),
        .byte_in   (in_data),
        .word_out  (pk_word),
        .word_done (pk_done)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chk_d       = chk_q;
        widx_d      = widx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_rst_d  = core_rst_q;
        done_d      = done_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (pk_clr) begin
                    state_d = ST_LEN_HI;
                    chk_d   = '0;
                    widx_d  = '0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    chk_d       = chk_q ^ in_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = len_in;
                    chk_d = chk_q ^ in_data;
                    if ({1'b0, len_in} > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else if (len_in == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    chk_d = chk_q ^ in_data;
                    if (pk_done) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = widx_q[PC_WIDTH-1:0];
                        mem_wdata_d = pk_word;
                        widx_d      = widx_q + IDX_WIDTH'(1);
                        if (16'(widx_q) + 16'd1 == len_q) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (load_req) begin
                    state_d    = ST_IDLE;
                    core_rst_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            chk_q       <= '0;
            widx_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            widx_q      <= widx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
